// File: rtl/corrida_pkg.sv
// Shared types and constants for the ride sequencer.
package corrida_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BUSCA    = 3'd1,
        EMBARQUE = 3'd2,
        VIAGEM   = 3'd3,
        CHEGADA  = 3'd4
    } estado_t;

    localparam logic [8:0] GARAGEM       = 9'b000000001;
    localparam logic [7:0] EMBARQUE_LEDG = 8'h0F;
    localparam logic [7:0] CHEGADA_LEDG  = 8'hFF;

    // True when exactly one bit of v is set.
    function automatic logic um_quente(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

endpackage

// File: rtl/corrida_if.sv
// Request and LED-side signals of the ride sequencer.
interface corrida_if;
    logic       pedido;
    logic [8:0] inicio;
    logic [8:0] fim;
    logic       cancela;
    logic [8:0] fio;
    logic [7:0] acende_verde;
    logic       ocupado;
    logic       aceito;
    logic       erro;
    logic [2:0] estado;
    logic [3:0] distancia;

    modport master (
        output pedido, inicio, fim, cancela,
        input  fio, acende_verde, ocupado, aceito, erro, estado, distancia
    );

    modport slave (
        input  pedido, inicio, fim, cancela,
        output fio, acende_verde, ocupado, aceito, erro, estado, distancia
    );
endinterface

// File: rtl/corrida_ctrl_divisor_passo.sv
// Step-tick prescaler: one-cycle passo every DIV cycles, restartable via limpa.
module divisor_passo #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic limpa,
    output logic passo
);
    localparam int             CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  ULTIMO = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Tick on the last count; wrap or restart from zero.
    always_comb begin
        passo = (cnt_q == ULTIMO);
        cnt_d = (limpa || passo) ? '0 : cnt_q + CW'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/corrida_ctrl.sv
// Ride sequencer: drives the driver toward pickup, boards, travels, shows arrival.
//
// state    | meaning
// IDLE     | waiting for a ride request
// BUSCA    | driver moving toward pickup (inicio)
// EMBARQUE | boarding, LEDG 0x0F for T_EMBARQUE ticks
// VIAGEM   | moving toward destination (fim), counting steps
// CHEGADA  | arrival, LEDG 0xFF for T_CHEGADA ticks
module corrida_ctrl
    import corrida_pkg::*;
#(
    parameter int DIV_PASSO  = 50_000_000,
    parameter int T_EMBARQUE = 3,
    parameter int T_CHEGADA  = 2
) (
    input  logic      clk,
    input  logic      reset,
    corrida_if.slave  bus
);
    localparam logic [7:0] EMB_ULT = 8'(T_EMBARQUE - 1);
    localparam logic [7:0] CHG_ULT = 8'(T_CHEGADA - 1);

    estado_t    state_q, state_d;
    logic [8:0] fio_q, fio_d, inicio_q, inicio_d, fim_q, fim_d;
    logic [7:0] verde_q, verde_d, ticks_q, ticks_d;
    logic [3:0] dist_q, dist_d;
    logic       ocupado_q, ocupado_d, aceito_q, aceito_d, erro_q, erro_d;
    logic       passo, limpa;

    divisor_passo #(.DIV(DIV_PASSO)) u_divisor (
        .clk   (clk),
        .reset (reset),
        .limpa (limpa),
        .passo (passo)
    );

    // Next-state logic; arrival takes priority over a step so both never coincide.
    always_comb begin
        state_d  = state_q;
        fio_d    = fio_q;
        inicio_d = inicio_q;
        fim_d    = fim_q;
        ticks_d  = ticks_q;
        dist_d   = dist_q;
        aceito_d = 1'b0;
        erro_d   = bus.pedido && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.pedido) begin
                    if (um_quente(bus.inicio) && um_quente(bus.fim) && (bus.inicio != bus.fim)) begin
                        inicio_d = bus.inicio;
                        fim_d    = bus.fim;
                        dist_d   = 4'd0;
                        aceito_d = 1'b1;
                        state_d  = BUSCA;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            BUSCA: begin
                if (bus.cancela)              state_d = IDLE;
                else if (fio_q == inicio_q)   state_d = EMBARQUE;
                else if (passo)               fio_d = (fio_q > inicio_q) ? (fio_q >> 1) : (fio_q << 1);
            end
            EMBARQUE: begin
                if (bus.cancela)              state_d = IDLE;
                else if (passo) begin
                    if (ticks_q == EMB_ULT)   state_d = VIAGEM;
                    else                      ticks_d = ticks_q + 8'd1;
                end
            end
            VIAGEM: begin
                if (fio_q == fim_q)           state_d = CHEGADA;
                else if (passo) begin
                    fio_d  = (fio_q > fim_q) ? (fio_q >> 1) : (fio_q << 1);
                    dist_d = dist_q + 4'd1;
                end
            end
            CHEGADA: begin
                if (passo) begin
                    if (ticks_q == CHG_ULT)   state_d = IDLE;
                    else                      ticks_d = ticks_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every state starts with a fresh prescaler and tick count.
        limpa = (state_d != state_q);
        if (limpa) ticks_d = 8'd0;

        ocupado_d = (state_d != IDLE);
        case (state_d)
            EMBARQUE: verde_d = EMBARQUE_LEDG;
            CHEGADA:  verde_d = CHEGADA_LEDG;
            default:  verde_d = 8'h00;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            fio_q     <= GARAGEM;
            inicio_q  <= GARAGEM;
            fim_q     <= GARAGEM;
            ticks_q   <= 8'd0;
            dist_q    <= 4'd0;
            verde_q   <= 8'h00;
            ocupado_q <= 1'b0;
            aceito_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fio_q     <= fio_d;
            inicio_q  <= inicio_d;
            fim_q     <= fim_d;
            ticks_q   <= ticks_d;
            dist_q    <= dist_d;
            verde_q   <= verde_d;
            ocupado_q <= ocupado_d;
            aceito_q  <= aceito_d;
            erro_q    <= erro_d;
        end
    end

    assign bus.fio          = fio_q;
    assign bus.acende_verde = verde_q;
    assign bus.ocupado      = ocupado_q;
    assign bus.aceito       = aceito_q;
    assign bus.erro         = erro_q;
    assign bus.estado       = state_q;
    assign bus.distancia    = dist_q;
endmodule

// File: tb/tb_corrida_ctrl.sv
// Directed bench for corrida_ctrl with a small response/movement scoreboard.
module tb_corrida_ctrl;
    import corrida_pkg::*;

    localparam int DIV = 4;
    localparam int TE  = 3;
    localparam int TC  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    corrida_if bus ();

    corrida_ctrl #(.DIV_PASSO(DIV), .T_EMBARQUE(TE), .T_CHEGADA(TC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests  = 0;
    int failed = 0;

    typedef struct { logic aceito; logic erro; } resp_t;
    typedef struct { logic [8:0] fio; int cyc; } mov_t;
    resp_t resp_q[$];
    mov_t  mov_q[$];

    localparam logic [8:0] B0 = 9'b000000001, B1 = 9'b000000010, B2 = 9'b000000100,
                           B3 = 9'b000001000, B4 = 9'b000010000, B5 = 9'b000100000,
                           B6 = 9'b001000000;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] ini, input logic [8:0] f,
                        input logic ac, input logic er, input string tag);
        resp_t r;
        bus.pedido = 1'b1;
        bus.inicio = ini;
        bus.fim    = f;
        resp_q.push_back(resp_t'{ac, er});
        tick();
        bus.pedido = 1'b0;
        r = resp_q.pop_front();
        cmp({tag, ".aceito"}, 32'(bus.aceito), 32'(r.aceito));
        cmp({tag, ".erro"},   32'(bus.erro),   32'(r.erro));
    endtask

    task automatic expect_move(input logic [8:0] f, input int cyc);
        mov_q.push_back(mov_t'{f, cyc});
    endtask

    task automatic wait_move(input string tag);
        mov_t e;
        logic [8:0] old;
        int n;
        e   = mov_q.pop_front();
        old = bus.fio;
        n   = 0;
        while (bus.fio === old && n < 64) begin
            tick();
            n++;
        end
        cmp({tag, ".fio"},    32'(bus.fio), 32'(e.fio));
        cmp({tag, ".ciclos"}, 32'(n),       32'(e.cyc));
    endtask

    task automatic wait_estado(input logic [2:0] st, input int cyc, input string tag);
        int n;
        n = 0;
        while (bus.estado !== st && n < 64) begin
            tick();
            n++;
        end
        cmp({tag, ".estado"}, 32'(bus.estado), 32'(st));
        cmp({tag, ".ciclos"}, 32'(n),          32'(cyc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pedido  = 1'b0;
        bus.inicio  = '0;
        bus.fim     = '0;
        bus.cancela = 1'b0;
        reset       = 1'b1;
        tick();
        tick();
        cmp("rst.fio",     32'(bus.fio),          32'(B0));
        cmp("rst.verde",   32'(bus.acende_verde), 32'h0);
        cmp("rst.ocupado", 32'(bus.ocupado),      32'h0);
        cmp("rst.aceito",  32'(bus.aceito),       32'h0);
        cmp("rst.erro",    32'(bus.erro),         32'h0);
        cmp("rst.estado",  32'(bus.estado),       32'h0);
        cmp("rst.dist",    32'(bus.distancia),    32'h0);
        reset = 1'b0;
        tick();

        // Full ride: pickup bit3, destination bit1.
        expect_move(B1, DIV);
        expect_move(B2, DIV);
        expect_move(B3, DIV);
        send(B3, B1, 1'b1, 1'b0, "t1.pedido");
        cmp("t1.estado_busca", 32'(bus.estado),  32'd1);
        cmp("t1.ocupado",      32'(bus.ocupado), 32'd1);
        wait_move("t1.busca1");
        wait_move("t1.busca2");
        wait_move("t1.busca3");
        wait_estado(3'd2, 1, "t1.embarque");
        cmp("t1.verde_emb", 32'(bus.acende_verde), 32'h0F);
        wait_estado(3'd3, TE * DIV, "t1.viagem");
        cmp("t1.verde_via", 32'(bus.acende_verde), 32'h00);
        expect_move(B2, DIV);
        expect_move(B1, DIV);
        wait_move("t1.viagem1");
        wait_move("t1.viagem2");
        cmp("t1.dist", 32'(bus.distancia), 32'd2);
        wait_estado(3'd4, 1, "t1.chegada");
        cmp("t1.verde_chg", 32'(bus.acende_verde), 32'hFF);
        wait_estado(3'd0, TC * DIV, "t1.idle");
        cmp("t1.fio_final", 32'(bus.fio),          32'(B1));
        cmp("t1.verde_fim", 32'(bus.acende_verde), 32'h00);
        cmp("t1.livre",     32'(bus.ocupado),      32'd0);

        // Malformed requests in IDLE.
        send(9'b000000101, B4, 1'b0, 1'b1, "t2.nao_um_quente");
        cmp("t2a.estado", 32'(bus.estado), 32'd0);
        cmp("t2a.fio",    32'(bus.fio),    32'(B1));
        tick();
        cmp("t2.erro_pulso", 32'(bus.erro), 32'd0);
        send(B4, B4, 1'b0, 1'b1, "t2.iguais");
        cmp("t2b.estado", 32'(bus.estado), 32'd0);
        cmp("t2b.fio",    32'(bus.fio),    32'(B1));

        // Pickup already at fio, then an intruding pedido during VIAGEM.
        send(B1, B3, 1'b1, 1'b0, "t3.pedido");
        wait_estado(3'd2, 1, "t3.busca_curta");
        wait_estado(3'd3, TE * DIV, "t3.viagem");
        send(B5, B6, 1'b0, 1'b1, "t3.intruso");
        cmp("t3.estado_mantido", 32'(bus.estado), 32'd3);
        expect_move(B2, DIV - 1);
        expect_move(B3, DIV);
        wait_move("t3.viagem1");
        wait_move("t3.viagem2");
        cmp("t3.dist", 32'(bus.distancia), 32'd2);
        wait_estado(3'd4, 1, "t3.chegada");
        wait_estado(3'd0, TC * DIV, "t3.idle");
        cmp("t3.fio_final",  32'(bus.fio),       32'(B3));
        cmp("t3.dist_final", 32'(bus.distancia), 32'd2);

        // Cancel during BUSCA at bit2, then new ride from there.
        expect_move(B2, DIV);
        send(B0, B5, 1'b1, 1'b0, "t4.pedido");
        wait_move("t4.busca1");
        bus.cancela = 1'b1;
        tick();
        bus.cancela = 1'b0;
        cmp("t4.cancel_estado",  32'(bus.estado),       32'd0);
        cmp("t4.cancel_fio",     32'(bus.fio),          32'(B2));
        cmp("t4.cancel_ocupado", 32'(bus.ocupado),      32'd0);
        cmp("t4.cancel_verde",   32'(bus.acende_verde), 32'h00);
        send(B2, B4, 1'b1, 1'b0, "t4.novo");
        cmp("t4.novo_busca", 32'(bus.estado), 32'd1);
        tick();
        cmp("t4.busca_1ciclo", 32'(bus.estado),       32'd2);
        cmp("t4.verde_emb",    32'(bus.acende_verde), 32'h0F);

        // Cancel during VIAGEM is ignored.
        wait_estado(3'd3, TE * DIV, "t5.viagem");
        bus.cancela = 1'b1;
        tick();
        bus.cancela = 1'b0;
        cmp("t5.cancel_ignorado", 32'(bus.estado), 32'd3);
        expect_move(B3, DIV - 1);
        expect_move(B4, DIV);
        wait_move("t5.viagem1");
        wait_move("t5.viagem2");
        wait_estado(3'd4, 1, "t5.chegada");
        wait_estado(3'd0, TC * DIV, "t5.idle");
        cmp("t5.fio_final", 32'(bus.fio),       32'(B4));
        cmp("t5.dist",      32'(bus.distancia), 32'd2);

        // Reset in the middle of EMBARQUE.
        expect_move(B3, DIV);
        expect_move(B2, DIV);
        send(B2, B6, 1'b1, 1'b0, "t6.pedido");
        wait_move("t6.busca1");
        wait_move("t6.busca2");
        wait_estado(3'd2, 1, "t6.embarque");
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cmp("t6.fio",     32'(bus.fio),          32'(B0));
        cmp("t6.verde",   32'(bus.acende_verde), 32'h00);
        cmp("t6.estado",  32'(bus.estado),       32'd0);
        cmp("t6.ocupado", 32'(bus.ocupado),      32'd0);
        cmp("t6.dist",    32'(bus.distancia),    32'd0);
        tick();
        cmp("t6.fica_idle", 32'(bus.estado), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
